// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The result is evaluated from latched operands and committed on the last Busy cycle.
//
// state | meaning
// IDLE  | waiting for Start; mthi/mtlo complete here in one edge
// RUN   | mult/div in flight, counter counts down to the commit edge
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;

  logic        is_mult;
  logic        is_signed;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] den;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        last;

  assign Busy = (state == RUN);
  assign last = (state == RUN) && (cnt == CNT_TC);

  // Multiplier and divider are single combinational blocks: the operands are
  // stable for the whole RUN window, so these are multicycle paths.
  always_comb begin
    is_mult   = (op_q == OP_MULT) || (op_q == OP_MULTU);
    is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    if (is_signed) begin
      prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    end else begin
      prod = {32'h0, a_q} * {32'h0, b_q};
    end
    // Sign-magnitude division keeps 0x80000000 / -1 well defined.
    a_neg = is_signed && a_q[31];
    b_neg = is_signed && b_q[31];
    a_mag = a_neg ? (32'h0 - a_q) : a_q;
    b_mag = b_neg ? (32'h0 - b_q) : b_q;
    den   = (b_mag == 32'h0) ? 32'h1 : b_mag;
    q_mag = a_mag / den;
    r_mag = a_mag % den;
    quo   = (a_neg ^ b_neg) ? (32'h0 - q_mag) : q_mag;
    rem   = a_neg ? (32'h0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= 3'd0;
      a_q   <= 32'h0;
      b_q   <= 32'h0;
      HI    <= 32'h0;
      LO    <= 32'h0;
    end else if (Flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            case (MdOp)
              OP_MULT, OP_MULTU: begin
                op_q  <= MdOp;
                a_q   <= A;
                b_q   <= B;
                cnt   <= MULT_N;
                state <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                op_q  <= MdOp;
                a_q   <= A;
                b_q   <= B;
                cnt   <= DIV_N;
                state <= RUN;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (last) begin
            state <= IDLE;
            cnt   <= '0;
            if (is_mult) begin
              HI <= prod[63:32];
              LO <= prod[31:0];
            end else if (b_q != 32'h0) begin
              HI <= rem;
              LO <= quo;
            end
          end else begin
            cnt <= cnt - CNT_TC;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
